axis_pkt_arbiter: RTL and testbench

- Packet-level round-robin arbiter that shares one 512-bit AXI-Stream datapath between NUM_PORTS packet sources, for example several pkt_replay instances feeding the sync FIFO / pkt_writer chain.
- A grant is held from the first beat to the tlast beat, so packets are never interleaved.
- Sits between the traffic sources and the downstream FIFO, in the core_clk domain.

---
 rtl/axis_pkt_arbiter.sv | 176 +++++++++++++++++
 tb/tb_axis_pkt_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_pkt_arbiter.sv
// Packet-level round-robin arbiter: shares one AXI-Stream datapath among NUM_PORTS sources.
// Optional AXIS_PKT_ARBITER_OUTREG_EN: m_axis outputs come from a 2-entry skid register slice.
module axis_pkt_arbiter #(
    parameter int NUM_PORTS   = 4,
    parameter int TDATA_WIDTH = 512
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_PORTS*TDATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [NUM_PORTS*TDATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic [NUM_PORTS-1:0]                s_axis_tlast,
    input  logic [NUM_PORTS-1:0]                s_axis_tvalid,
    output logic [NUM_PORTS-1:0]                s_axis_tready,
    output logic [TDATA_WIDTH-1:0]              m_axis_tdata,
    output logic [TDATA_WIDTH/8-1:0]            m_axis_tkeep,
    output logic                                m_axis_tlast,
    output logic                                m_axis_tvalid,
    input  logic                                m_axis_tready,
    output logic [NUM_PORTS-1:0]                grant,
    output logic                                busy
);
    localparam int KEEP_W = TDATA_WIDTH / 8;
    localparam int IDX_W  = $clog2(NUM_PORTS);
    localparam logic [IDX_W:0] PORTS_EXT = (IDX_W+1)'(NUM_PORTS);

    typedef enum logic {IDLE, XFER} state_t;

    state_t               state_reg, state_next;
    logic [NUM_PORTS-1:0] grant_reg, grant_next;
    logic [IDX_W-1:0]     last_reg, last_next;

    // Candidate order for arbitration: last+1, last+2, ... wrapping at NUM_PORTS.
    logic [IDX_W:0]   cand_sum [NUM_PORTS];
    logic [IDX_W-1:0] cand_idx [NUM_PORTS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_cand
            assign cand_sum[gi] = {1'b0, last_reg} + (IDX_W+1)'(gi + 1);
            assign cand_idx[gi] = (cand_sum[gi] >= PORTS_EXT) ? IDX_W'(cand_sum[gi] - PORTS_EXT)
                                                              : cand_sum[gi][IDX_W-1:0];
        end
    endgenerate

    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        // Scan from the far end so the nearest requester after last wins.
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            if (s_axis_tvalid[cand_idx[k]]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx[k];
            end
        end
    end

    logic [TDATA_WIDTH-1:0] sel_data;
    logic [KEEP_W-1:0]      sel_keep;
    logic                   sel_last;
    logic                   sel_valid;
    logic                   in_ready;
    logic                   in_fire;

    always_comb begin
        sel_data = '0;
        sel_keep = '0;
        sel_last = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant_reg[i]) begin
                sel_data = s_axis_tdata[i*TDATA_WIDTH +: TDATA_WIDTH];
                sel_keep = s_axis_tkeep[i*KEEP_W +: KEEP_W];
                sel_last = s_axis_tlast[i];
            end
        end
    end

    assign sel_valid     = |(grant_reg & s_axis_tvalid);
    assign in_fire       = sel_valid & in_ready;
    assign s_axis_tready = grant_reg & {NUM_PORTS{in_ready}};
    assign grant         = grant_reg;
    assign busy          = (state_reg == XFER);

    always_comb begin
        state_next = state_reg;
        grant_next = grant_reg;
        last_next  = last_reg;
        case (state_reg)
            IDLE: begin
                if (pick_found) begin
                    state_next = XFER;
                    grant_next = NUM_PORTS'(1) << pick_idx;
                    last_next  = pick_idx;
                end
            end
            XFER: begin
                if (in_fire && sel_last) begin
                    state_next = IDLE;
                    grant_next = '0;
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            grant_reg <= '0;
            last_reg  <= IDX_W'(NUM_PORTS - 1);
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
            last_reg  <= last_next;
        end
    end

`ifdef AXIS_PKT_ARBITER_OUTREG_EN
    // Two-entry slice: upstream ready depends only on occupancy, so full rate survives the register.
    logic [TDATA_WIDTH-1:0] skid_data [2];
    logic [KEEP_W-1:0]      skid_keep [2];
    logic [1:0]             skid_last;
    logic                   wr_ptr_reg;
    logic                   rd_ptr_reg;
    logic [1:0]             count_reg;
    logic                   skid_pop;

    assign in_ready = (count_reg != 2'd2);
    assign skid_pop = (count_reg != 2'd0) && m_axis_tready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (in_fire) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (skid_pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            case ({in_fire, skid_pop})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (in_fire) begin
            skid_data[wr_ptr_reg] <= sel_data;
            skid_keep[wr_ptr_reg] <= sel_keep;
            skid_last[wr_ptr_reg] <= sel_last;
        end
    end

    assign m_axis_tvalid = (count_reg != 2'd0);
    assign m_axis_tdata  = skid_data[rd_ptr_reg];
    assign m_axis_tkeep  = skid_keep[rd_ptr_reg];
    assign m_axis_tlast  = skid_last[rd_ptr_reg];
`else
    assign in_ready      = m_axis_tready;
    assign m_axis_tvalid = sel_valid;
    assign m_axis_tdata  = sel_data;
    assign m_axis_tkeep  = sel_keep;
    assign m_axis_tlast  = sel_last;
`endif

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// Self-checking bench for axis_pkt_arbiter: directed scenarios plus randomized traffic,
// compared each cycle against a queue-based behavioural model of the arbiter.
module tb_axis_pkt_arbiter;
    localparam int N = 4;
    localparam int W = 512;
    localparam int K = W / 8;
`ifdef AXIS_PKT_ARBITER_OUTREG_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N*W-1:0] s_tdata = '0;
    logic [N*K-1:0] s_tkeep = '0;
    logic [N-1:0]   s_tlast = '0;
    logic [N-1:0]   s_tvalid = '0;
    logic [N-1:0]   s_tready;
    logic [W-1:0]   m_tdata;
    logic [K-1:0]   m_tkeep;
    logic           m_tlast;
    logic           m_tvalid;
    logic           m_tready = 1'b0;
    logic [N-1:0]   grant;
    logic           busy;

    always #5 clk = ~clk;

    axis_pkt_arbiter #(.NUM_PORTS(N), .TDATA_WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast),
        .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .grant(grant), .busy(busy)
    );

    typedef struct {
        logic [W-1:0] d;
        logic [K-1:0] k;
        logic         l;
    } beat_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Source state: a presented beat is held until the model says it was accepted.
    logic         pv [N];
    logic [W-1:0] pd [N];
    logic [K-1:0] pk [N];
    logic         pl [N];
    int rem [N], cnt [N], pkts_left [N], p_valid [N], gap [N], gap_arm [N], len_lo [N], len_hi [N];
    int p_ready = 100;
    int ready_q [$];
    bit keep_full = 1'b0;

    // Behavioural model: owner port (-1 idle), round-robin pointer, output slice contents.
    int    owner = -1;
    int    lastp = N - 1;
    beat_t q [$];

    int g_port [$];
    int g_cyc [$];
    int idle_cyc [$];
    int o_cyc [$];
    logic [31:0] o_lo [$];
    logic o_last [$];
    int cur_pkt_port = -1;
    int dut_in = 0;
    int dut_out = 0;
    logic prev_stall = 1'b0;
    logic [W-1:0] prev_data = '0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int oc(input int idx);
        return (idx < o_cyc.size()) ? o_cyc[idx] : -1;
    endfunction

    function automatic logic [31:0] ol(input int idx);
        return (idx < o_lo.size()) ? o_lo[idx] : 32'hdeadbeef;
    endfunction

    function automatic logic olast(input int idx);
        return (idx < o_last.size()) ? o_last[idx] : 1'bx;
    endfunction

    function automatic int gp(input int idx);
        return (idx < g_port.size()) ? g_port[idx] : -1;
    endfunction

    function automatic int gc(input int idx);
        return (idx < g_cyc.size()) ? g_cyc[idx] : -1;
    endfunction

    function automatic bit pending();
        bit p = (owner >= 0) || (q.size() > 0);
        for (int i = 0; i < N; i++) begin
            if (pv[i] || rem[i] > 0 || pkts_left[i] > 0) p = 1'b1;
        end
        return p;
    endfunction

    task automatic step();
        logic [N-1:0] eg, er;
        logic ev, up_fire, dn_fire;
        beat_t eb;
        int uo;
        @(negedge clk);
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (!pv[i]) begin
                if (gap[i] > 0) begin
                    gap[i]--;
                end else if (rem[i] > 0 && gap_arm[i] > 0) begin
                    gap[i] = gap_arm[i] - 1;
                    gap_arm[i] = 0;
                end else if ((rem[i] > 0 || pkts_left[i] > 0) && $urandom_range(99) < p_valid[i]) begin
                    if (rem[i] == 0) begin
                        rem[i] = $urandom_range(len_hi[i], len_lo[i]);
                        pkts_left[i]--;
                    end
                    cnt[i]++;
                    for (int w = 0; w < W / 32; w++) pd[i][w*32 +: 32] = $urandom;
                    pd[i][31:0] = {i[7:0], cnt[i][23:0]};
                    for (int b = 0; b < K; b++) pk[i][b] = keep_full ? 1'b1 : 1'($urandom_range(1));
                    pl[i] = (rem[i] == 1);
                    rem[i]--;
                    pv[i] = 1'b1;
                end
            end
            s_tvalid[i]         = pv[i];
            s_tdata[i*W +: W]   = pd[i];
            s_tkeep[i*K +: K]   = pk[i];
            s_tlast[i]          = pl[i];
        end
        if (ready_q.size() > 0) m_tready = 1'(ready_q.pop_front());
        else                    m_tready = ($urandom_range(99) < p_ready);
        #1;
        eg = (owner >= 0) ? (N'(1) << owner) : '0;
`ifdef AXIS_PKT_ARBITER_OUTREG_EN
        ev = (q.size() > 0);
        if (ev) eb = q[0];
        er = (owner >= 0 && q.size() < 2) ? eg : '0;
        up_fire = (owner >= 0) && pv[owner] && (q.size() < 2);
`else
        ev = (owner >= 0) && pv[owner];
        if (ev) eb = '{pd[owner], pk[owner], pl[owner]};
        er = (owner >= 0 && m_tready) ? eg : '0;
        up_fire = ev && m_tready;
`endif
        dn_fire = ev && m_tready;
        chk("grant", grant, eg);
        chk("busy", busy, owner >= 0);
        chk("s_tready", s_tready, er);
        chk("m_tvalid", m_tvalid, ev);
        if (ev) begin
            chk("m_tdata", m_tdata, eb.d);
            chk("m_tkeep", m_tkeep, eb.k);
            chk("m_tlast", m_tlast, eb.l);
        end
        if (prev_stall) chk("stall_hold", m_tdata, prev_data);
        prev_stall = ev && !m_tready;
        prev_data  = m_tdata;
        dut_in  += $countones(s_tvalid & s_tready);
        dut_out += (m_tvalid && m_tready) ? 1 : 0;
        if (m_tvalid && m_tready) begin
            o_cyc.push_back(cyc);
            o_lo.push_back(m_tdata[31:0]);
            o_last.push_back(m_tlast);
            if (cur_pkt_port >= 0) chk("no_interleave", m_tdata[31:24], cur_pkt_port[7:0]);
            cur_pkt_port = m_tlast ? -1 : int'(m_tdata[31:24]);
        end
        uo = owner;
`ifdef AXIS_PKT_ARBITER_OUTREG_EN
        if (dn_fire) q.delete(0);
        if (up_fire) q.push_back('{pd[uo], pk[uo], pl[uo]});
`endif
        if (up_fire) pv[uo] = 1'b0;
        if (uo < 0) begin
            for (int k = 1; k <= N; k++) begin
                int j;
                j = (lastp + k) % N;
                if (pv[j] && owner < 0) begin
                    owner = j;
                    lastp = j;
                    g_port.push_back(j);
                    g_cyc.push_back(cyc + 1);
                end
            end
        end else if (up_fire && pl[uo]) begin
            owner = -1;
            idle_cyc.push_back(cyc + 1);
        end
    endtask

    task automatic clear_sources();
        for (int i = 0; i < N; i++) begin
            pv[i] = 1'b0; rem[i] = 0; pkts_left[i] = 0; gap[i] = 0; gap_arm[i] = 0;
            p_valid[i] = 0; len_lo[i] = 1; len_hi[i] = 1;
        end
    endtask

    // Pulls rst_n low between clock edges and checks the outputs drop without a clock.
    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_m_tvalid", m_tvalid, 1'b0);
        chk("rst_grant", grant, '0);
        chk("rst_s_tready", s_tready, '0);
        chk("rst_busy", busy, 1'b0);
        clear_sources();
        s_tvalid = '0;
        owner = -1; lastp = N - 1; q.delete();
        cur_pkt_port = -1; prev_stall = 1'b0; dut_in = 0; dut_out = 0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    int bo, bg, c0, cnt0, guard;

    initial begin
        for (int i = 0; i < N; i++) begin
            pd[i] = '0; pk[i] = '0; pl[i] = 1'b0; cnt[i] = 0;
        end
        clear_sources();
        #3;
        chk("init_grant", grant, '0);
        chk("init_busy", busy, 1'b0);
        chk("init_m_tvalid", m_tvalid, 1'b0);
        chk("init_s_tready", s_tready, '0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // All ports streaming 2-beat packets: order 0,1,2,3,0 with one bubble each.
        bg = g_port.size();
        for (int i = 0; i < N; i++) begin
            pkts_left[i] = 2; len_lo[i] = 2; len_hi[i] = 2; p_valid[i] = 100;
        end
        p_ready = 100;
        repeat (30) step();
        for (int n = 0; n < 5; n++) chk("rr_order", gp(bg + n), n % N);
        for (int n = 1; n < 5; n++) chk("rr_spacing", gc(bg + n) - gc(bg + n - 1), 3);

        // Single source: port 0, 3 beats, data 1/2/3, all-ones tkeep.
        clear_sources();
        keep_full = 1'b1;
        cnt[0] = 0;
        bo = o_cyc.size(); bg = g_port.size(); c0 = cyc + 1;
        pkts_left[0] = 1; len_lo[0] = 3; len_hi[0] = 3; p_valid[0] = 100;
        repeat (8) step();
        chk("s1_grant_port", gp(bg), 0);
        chk("s1_grant_cyc", gc(bg), c0 + 1);
        chk("s1_beats", o_cyc.size() - bo, 3);
        for (int b = 0; b < 3; b++) begin
            chk("s1_beat_cyc", oc(bo + b), c0 + 1 + LAT + b);
            chk("s1_beat_data", ol(bo + b), b + 1);
            chk("s1_beat_last", olast(bo + b), b == 2);
        end
        chk("s1_busy_fall", idle_cyc[idle_cyc.size() - 1], c0 + 4);
        keep_full = 1'b0;

        // Backpressure on a 4-beat packet from port 2.
        clear_sources();
        bo = o_cyc.size(); cnt0 = cnt[2];
        pkts_left[2] = 1; len_lo[2] = 4; len_hi[2] = 4; p_valid[2] = 100;
        ready_q = '{1, 1, 0, 0, 1, 1, 1, 1};
        repeat (12) step();
        chk("bp_beats", o_cyc.size() - bo, 4);
        for (int b = 0; b < 4; b++) chk("bp_data", ol(bo + b), {8'd2, 24'(cnt0 + b + 1)});

        // Source gap: port 1 stalls 5 cycles mid-packet while port 3 waits.
        clear_sources();
        bo = o_cyc.size(); bg = g_port.size();
        pkts_left[1] = 1; len_lo[1] = 3; len_hi[1] = 3; p_valid[1] = 100; gap_arm[1] = 5;
        repeat (2) step();
        pkts_left[3] = 1; len_lo[3] = 2; len_hi[3] = 2; p_valid[3] = 100;
        repeat (16) step();
        chk("gap_first", gp(bg), 1);
        chk("gap_second", gp(bg + 1), 3);
        chk("gap_spacing", oc(bo + 1) - oc(bo), 6);
        chk("gap_order", ol(bo + 3) >> 24, 3);
        chk("gap_beats", o_cyc.size() - bo, 5);

        // Reset during beat 2 of a 4-beat packet from port 0.
        clear_sources();
        bo = o_cyc.size();
        pkts_left[0] = 1; len_lo[0] = 4; len_hi[0] = 4; p_valid[0] = 100;
        guard = 0;
        while (o_cyc.size() == bo && guard < 20) begin
            step();
            guard++;
        end
        chk("rst_reach_beat1", guard < 20, 1'b1);
        step();
        async_reset();
        bg = g_port.size();
        pkts_left[0] = 1; len_lo[0] = 2; len_hi[0] = 2; p_valid[0] = 100;
        pkts_left[2] = 1; len_lo[2] = 2; len_hi[2] = 2; p_valid[2] = 100;
        repeat (10) step();
        chk("rst_first_port", gp(bg), 0);
        chk("rst_second_port", gp(bg + 1), 2);

        // Randomized traffic with random backpressure.
        for (int i = 0; i < N; i++) begin
            pkts_left[i] = 40; len_lo[i] = 1; len_hi[i] = 6;
            p_valid[i] = $urandom_range(100, 30);
        end
        p_ready = 70;
        guard = 0;
        while (pending() && guard < 20000) begin
            step();
            guard++;
        end
        chk("drain_done", guard < 20000, 1'b1);
        chk("conservation", dut_out, dut_in);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
